// File: rtl/stream_max_argmax_pkg.sv
// Shared definitions for the streaming extremum finder.
//   mode_e  : per-packet compare direction (MODE_MAX / MODE_MIN)
//   cmp_t   : common compare width; callers sign/zero-extend operands into it
//   better(): strict "a beats b" test; a tie is never better, so the
//             earlier (lower index) candidate always survives a tie.
package stream_max_argmax_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  // A challenger replaces the incumbent only when strictly better.
  localparam logic TIE_KEEP_LOWEST = 1'b1;

  localparam int unsigned CMP_W = 64;
  typedef logic [CMP_W-1:0] cmp_t;

  // True when a is strictly better than b under the given mode/signedness.
  function automatic logic better(input cmp_t a, input cmp_t b,
                                  input mode_e mode, input logic is_signed);
    logic gt;
    logic lt;
    if (is_signed) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return (mode == MODE_MIN) ? lt : gt;
  endfunction

endpackage

// File: rtl/stream_max_argmax_if.sv
// Beat input / result output bundle for stream_max_argmax.
//   s_valid/s_ready/s_data/s_last/s_mode_min : input beat stream
//   m_valid/m_ready/m_value/m_argmax/m_beats/m_overflow : result handshake
// slave = the reducer's view, master = the producer/consumer's view.
interface stream_max_argmax_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LANES_LOG2 = 2,
  parameter int unsigned IDX_W      = 16
);
  localparam int unsigned LANES = 1 << LANES_LOG2;
  localparam int unsigned CNT_W = IDX_W - LANES_LOG2;

  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*WIDTH-1:0] s_data;
  logic                   s_last;
  logic                   s_mode_min;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH-1:0]       m_value;
  logic [IDX_W-1:0]       m_argmax;
  logic [CNT_W:0]         m_beats;
  logic                   m_overflow;

  modport slave (
    input  s_valid, s_data, s_last, s_mode_min, m_ready,
    output s_ready, m_valid, m_value, m_argmax, m_beats, m_overflow
  );

  modport master (
    output s_valid, s_data, s_last, s_mode_min, m_ready,
    input  s_ready, m_valid, m_value, m_argmax, m_beats, m_overflow
  );
endinterface

// File: rtl/lane_reduce_tree.sv
// Combinational pairwise reduction of one beat's lanes to (value, lane).
//   data  : LANES*WIDTH packed lanes, lane i at data[WIDTH*i +: WIDTH]
//   mode  : max or min
//   value : winning element
//   lane  : winning lane; the lower lane wins any tie
module lane_reduce_tree
  import stream_max_argmax_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LANES_LOG2 = 2,
  parameter int unsigned SIGNED     = 0
) (
  input  logic [(WIDTH<<LANES_LOG2)-1:0] data,
  input  mode_e                          mode,
  output logic [WIDTH-1:0]               value,
  output logic [LANES_LOG2-1:0]          lane
);
  localparam int unsigned LANES = 1 << LANES_LOG2;

  function automatic cmp_t ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) return CMP_W'($signed(v));
    return CMP_W'(v);
  endfunction

  // Heap-ordered tree: leaves at LANES..2*LANES-1, node n has children 2n
  // (lower lanes) and 2n+1 (higher lanes); the root is node 1.
  always_comb begin : p_reduce
    logic [WIDTH-1:0]      v  [2*LANES];
    logic [LANES_LOG2-1:0] ix [2*LANES];
    v  = '{default: '0};
    ix = '{default: '0};
    for (int i = 0; i < LANES; i++) begin
      v[LANES+i]  = data[WIDTH*i +: WIDTH];
      ix[LANES+i] = LANES_LOG2'(i);
    end
    for (int n = LANES - 1; n >= 1; n--) begin
      if (better(ext(v[2*n+1]), ext(v[2*n]), mode, SIGNED != 0)) begin
        v[n]  = v[2*n+1];
        ix[n] = ix[2*n+1];
      end else begin
        v[n]  = v[2*n];
        ix[n] = ix[2*n];
      end
    end
    value = v[1];
    lane  = ix[1];
  end

endmodule

// File: rtl/stream_max_argmax.sv
// Streaming extremum finder: reduces a packet of multi-lane beats to one
// extreme value plus its global index (beat*LANES + lane).
//   clk, rst : clock and synchronous active-high reset
//   bus      : stream_max_argmax_if.slave (input beats, result handshake)
module stream_max_argmax
  import stream_max_argmax_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LANES_LOG2 = 2,
  parameter int unsigned IDX_W      = 16,
  parameter int unsigned SIGNED     = 0
) (
  input logic               clk,
  input logic               rst,
  stream_max_argmax_if.slave bus
);
  localparam int unsigned CNT_W = IDX_W - LANES_LOG2;

  function automatic cmp_t ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) return CMP_W'($signed(v));
    return CMP_W'(v);
  endfunction

  // Packet accumulator
  logic             first_q,   first_d;
  mode_e            mode_q,    mode_d;
  logic [WIDTH-1:0] acc_val_q, acc_val_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W:0]   beats_q,   beats_d;
  logic             ovf_q,     ovf_d;

  // Output register
  logic             m_valid_q,  m_valid_d;
  logic [WIDTH-1:0] m_value_q,  m_value_d;
  logic [IDX_W-1:0] m_argmax_q, m_argmax_d;
  logic [CNT_W:0]   m_beats_q,  m_beats_d;
  logic             m_ovf_q,    m_ovf_d;

  logic                  s_ready_c;
  logic                  accept_c;
  mode_e                 mode_c;
  logic [WIDTH-1:0]      beat_val_c;
  logic [LANES_LOG2-1:0] beat_lane_c;
  logic                  beat_sat_c;
  logic [CNT_W-1:0]      beat_num_c;
  logic [IDX_W-1:0]      beat_idx_c;
  logic                  take_beat_c;
  logic [WIDTH-1:0]      new_val_c;
  logic [IDX_W-1:0]      new_idx_c;
  logic [CNT_W:0]        beats_nxt_c;

  assign s_ready_c = !m_valid_q | bus.m_ready;
  assign accept_c  = bus.s_valid & s_ready_c;

  // Mode comes from the wire on the first beat, from the latch afterwards.
  assign mode_c = first_q ? mode_e'(bus.s_mode_min) : mode_q;

  lane_reduce_tree #(
    .WIDTH      (WIDTH),
    .LANES_LOG2 (LANES_LOG2),
    .SIGNED     (SIGNED)
  ) u_tree (
    .data  (bus.s_data),
    .mode  (mode_c),
    .value (beat_val_c),
    .lane  (beat_lane_c)
  );

  // Once beats_q reaches 2**CNT_W the beat number pins at all-ones.
  assign beat_sat_c  = beats_q[CNT_W];
  assign beat_num_c  = beat_sat_c ? {CNT_W{1'b1}} : beats_q[CNT_W-1:0];
  assign beat_idx_c  = {beat_num_c, beat_lane_c};
  assign beats_nxt_c = beat_sat_c ? beats_q : beats_q + (CNT_W+1)'(1);

  assign take_beat_c = first_q |
                       better(ext(beat_val_c), ext(acc_val_q), mode_c, SIGNED != 0);
  assign new_val_c   = take_beat_c ? beat_val_c : acc_val_q;
  assign new_idx_c   = take_beat_c ? beat_idx_c : acc_idx_q;

  // Next-state for accumulator and output register
  always_comb begin
    first_d    = first_q;
    mode_d     = mode_q;
    acc_val_d  = acc_val_q;
    acc_idx_d  = acc_idx_q;
    beats_d    = beats_q;
    ovf_d      = ovf_q;
    m_valid_d  = m_valid_q & ~bus.m_ready;
    m_value_d  = m_value_q;
    m_argmax_d = m_argmax_q;
    m_beats_d  = m_beats_q;
    m_ovf_d    = m_ovf_q;
    if (accept_c) begin
      if (bus.s_last) begin
        m_valid_d  = 1'b1;
        m_value_d  = new_val_c;
        m_argmax_d = new_idx_c;
        m_beats_d  = beats_nxt_c;
        m_ovf_d    = ovf_q | beat_sat_c;
        first_d    = 1'b1;
        beats_d    = '0;
        ovf_d      = 1'b0;
      end else begin
        first_d    = 1'b0;
        mode_d     = mode_c;
        acc_val_d  = new_val_c;
        acc_idx_d  = new_idx_c;
        beats_d    = beats_nxt_c;
        ovf_d      = ovf_q | beat_sat_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b1;
      mode_q     <= MODE_MAX;
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      beats_q    <= '0;
      ovf_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_value_q  <= '0;
      m_argmax_q <= '0;
      m_beats_q  <= '0;
      m_ovf_q    <= 1'b0;
    end else begin
      first_q    <= first_d;
      mode_q     <= mode_d;
      acc_val_q  <= acc_val_d;
      acc_idx_q  <= acc_idx_d;
      beats_q    <= beats_d;
      ovf_q      <= ovf_d;
      m_valid_q  <= m_valid_d;
      m_value_q  <= m_value_d;
      m_argmax_q <= m_argmax_d;
      m_beats_q  <= m_beats_d;
      m_ovf_q    <= m_ovf_d;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_value    = m_value_q;
  assign bus.m_argmax   = m_argmax_q;
  assign bus.m_beats    = m_beats_q;
  assign bus.m_overflow = m_ovf_q;

endmodule

// File: tb/tb_stream_max_argmax.sv
// Directed bench for stream_max_argmax. Three instances share one input
// stream: unsigned (IDX_W=16), signed (IDX_W=16) and unsigned with IDX_W=4
// so the beat counter saturates within a few beats.
module tb_stream_max_argmax;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_last, s_mode_min, m_ready;
  logic [31:0] s_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_max_argmax_if #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(16)) if_u ();
  stream_max_argmax_if #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(16)) if_s ();
  stream_max_argmax_if #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(4))  if_o ();

  assign if_u.s_valid = s_valid;  assign if_u.s_data = s_data;  assign if_u.s_last = s_last;
  assign if_u.s_mode_min = s_mode_min;  assign if_u.m_ready = m_ready;
  assign if_s.s_valid = s_valid;  assign if_s.s_data = s_data;  assign if_s.s_last = s_last;
  assign if_s.s_mode_min = s_mode_min;  assign if_s.m_ready = m_ready;
  assign if_o.s_valid = s_valid;  assign if_o.s_data = s_data;  assign if_o.s_last = s_last;
  assign if_o.s_mode_min = s_mode_min;  assign if_o.m_ready = m_ready;

  stream_max_argmax #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(16), .SIGNED(0))
    dut_u (.clk(clk), .rst(rst), .bus(if_u));
  stream_max_argmax #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(16), .SIGNED(1))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));
  stream_max_argmax #(.WIDTH(8), .LANES_LOG2(2), .IDX_W(4), .SIGNED(0))
    dut_o (.clk(clk), .rst(rst), .bus(if_o));

  typedef struct {
    string            name;
    int               sel;     // 0 unsigned, 1 signed, 2 short counter
    int               nb;
    logic [5:0][31:0] data;    // data[b] = beat b, lanes 3..0
    logic [5:0]       mode;    // s_mode_min per beat
    logic [31:0]      e_val;
    logic [31:0]      e_arg;
    logic [31:0]      e_beats;
    logic [31:0]      e_ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string name, input int sel, input int nb,
                              input logic [5:0] mode,
                              input logic [31:0] d0, d1, d2, d3, d4, d5,
                              input logic [31:0] ev, ea, eb, eo);
    vec_t v;
    v.name = name; v.sel = sel; v.nb = nb; v.mode = mode;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.data[3] = d3; v.data[4] = d4; v.data[5] = d5;
    v.e_val = ev; v.e_arg = ea; v.e_beats = eb; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic grab(input int sel, output logic [31:0] mv, output logic [31:0] val,
                      output logic [31:0] arg, output logic [31:0] bts, output logic [31:0] ovf);
    case (sel)
      1: begin
        mv = 32'(if_s.m_valid); val = 32'(if_s.m_value); arg = 32'(if_s.m_argmax);
        bts = 32'(if_s.m_beats); ovf = 32'(if_s.m_overflow);
      end
      2: begin
        mv = 32'(if_o.m_valid); val = 32'(if_o.m_value); arg = 32'(if_o.m_argmax);
        bts = 32'(if_o.m_beats); ovf = 32'(if_o.m_overflow);
      end
      default: begin
        mv = 32'(if_u.m_valid); val = 32'(if_u.m_value); arg = 32'(if_u.m_argmax);
        bts = 32'(if_u.m_beats); ovf = 32'(if_u.m_overflow);
      end
    endcase
  endtask

  // Present one beat and hold it until accepted (bounded); returns #1 after the accepting edge.
  task automatic send_beat(input string nm, input logic [31:0] d, input logic last, input logic mode);
    int n;
    s_valid = 1'b1; s_data = d; s_last = last; s_mode_min = mode;
    #1;
    n = 0;
    while (!if_u.s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk({nm, "_ready_timeout"}, 32'(if_u.s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  logic [31:0] mv, val, arg, bts, ovf;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("single_max", 0, 1, 6'b000000, 32'h107F7F03, 0, 0, 0, 0, 0,
                 32'h7F, 32'd1, 32'd1, 32'd0);
    vecs[1] = mk("three_beat_max", 0, 3, 6'b000000, 32'h01020304, 32'h10203040,
                 32'hF0EF0005, 0, 0, 0, 32'hF0, 32'd11, 32'd3, 32'd0);
    vecs[2] = mk("signed_min_held", 1, 2, 6'b000001, 32'h01020304, 32'h05060780,
                 0, 0, 0, 0, 32'h80, 32'd4, 32'd2, 32'd0);
    vecs[3] = mk("tie_across_beats", 0, 2, 6'b000000, 32'h00551020, 32'h30554001,
                 0, 0, 0, 0, 32'h55, 32'd2, 32'd2, 32'd0);
    vecs[4] = mk("unsigned_min_tie", 0, 2, 6'b000011, 32'h800303FF, 32'h03040506,
                 0, 0, 0, 0, 32'h03, 32'd1, 32'd2, 32'd0);
    vecs[5] = mk("signed_max", 1, 1, 6'b000000, 32'h7F80FF01, 0, 0, 0, 0, 0,
                 32'h7F, 32'd3, 32'd1, 32'd0);
    vecs[6] = mk("cnt_full_no_ovf", 2, 4, 6'b000000, 32'h10101010, 32'h10101010,
                 32'h10101010, 32'h00000099, 0, 0, 32'h99, 32'd12, 32'd4, 32'd0);
    vecs[7] = mk("cnt_overflow", 2, 6, 6'b000000, 32'h11111111, 32'h11111111,
                 32'h11111111, 32'h11111111, 32'h11111111, 32'h00002200,
                 32'h22, 32'd13, 32'd4, 32'd1);

    s_valid = 1'b0; s_last = 1'b0; s_mode_min = 1'b0; s_data = '0; m_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    grab(0, mv, val, arg, bts, ovf);
    chk("rst_m_valid", mv, 32'd0);
    chk("rst_m_value", val, 32'd0);
    chk("rst_m_argmax", arg, 32'd0);
    chk("rst_m_beats", bts, 32'd0);
    chk("rst_m_overflow", ovf, 32'd0);
    chk("rst_s_ready", 32'(if_u.s_ready), 32'd1);

    // Table: each packet's result must appear exactly one cycle after its last beat
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < vecs[i].nb; b++)
        send_beat(vecs[i].name, vecs[i].data[b], b == vecs[i].nb - 1, vecs[i].mode[b]);
      grab(vecs[i].sel, mv, val, arg, bts, ovf);
      chk({vecs[i].name, "_m_valid"}, mv, 32'd1);
      chk({vecs[i].name, "_m_value"}, val, vecs[i].e_val);
      chk({vecs[i].name, "_m_argmax"}, arg, vecs[i].e_arg);
      chk({vecs[i].name, "_m_beats"}, bts, vecs[i].e_beats);
      chk({vecs[i].name, "_m_overflow"}, ovf, vecs[i].e_ovf);
      @(posedge clk); #1;
      grab(vecs[i].sel, mv, val, arg, bts, ovf);
      chk({vecs[i].name, "_m_valid_drop"}, mv, 32'd0);
    end

    // Backpressure: pending result blocks the next packet, then hand-off in one cycle
    m_ready = 1'b0;
    send_beat("bp_a", 32'h01020304, 1'b1, 1'b0);
    grab(0, mv, val, arg, bts, ovf);
    chk("bp_a_valid", mv, 32'd1);
    chk("bp_a_value", val, 32'h04);
    s_valid = 1'b1; s_data = 32'h0000AA00; s_last = 1'b1; s_mode_min = 1'b0;
    #1;
    chk("bp_s_ready_low", 32'(if_u.s_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    grab(0, mv, val, arg, bts, ovf);
    chk("bp_hold_valid", mv, 32'd1);
    chk("bp_hold_value", val, 32'h04);
    chk("bp_hold_argmax", arg, 32'd0);
    chk("bp_hold_beats", bts, 32'd1);
    m_ready = 1'b1;
    #1;
    chk("bp_s_ready_high", 32'(if_u.s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    grab(0, mv, val, arg, bts, ovf);
    chk("bp_b_valid", mv, 32'd1);
    chk("bp_b_value", val, 32'hAA);
    chk("bp_b_argmax", arg, 32'd1);
    @(posedge clk); #1;
    grab(0, mv, val, arg, bts, ovf);
    chk("bp_b_drop", mv, 32'd0);

    // Reset in the middle of a packet discards the partial accumulation
    send_beat("rst_mid0", 32'hFFFFFFFF, 1'b0, 1'b0);
    send_beat("rst_mid1", 32'hFFFFFFFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat("rst_new", 32'h00000901, 1'b1, 1'b0);
    grab(0, mv, val, arg, bts, ovf);
    chk("rst_mid_valid", mv, 32'd1);
    chk("rst_mid_value", val, 32'h09);
    chk("rst_mid_argmax", arg, 32'd1);
    chk("rst_mid_beats", bts, 32'd1);
    chk("rst_mid_overflow", ovf, 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
